// File: rtl/axi4_w_pkg.sv
// Shared AXI4 W-channel types and field widths, also used by the AW arbiter.
package axi4_w_pkg;

   localparam int W_DATA_W = 64;
   localparam int W_ID_W   = 5;
   localparam int W_STRB_W = 8;
   localparam int W_USER_W = 1;

   typedef struct packed {
      logic [W_DATA_W-1:0] data;
      logic                last;
      logic [W_ID_W-1:0]   id;
      logic [W_STRB_W-1:0] strb;
      logic [W_USER_W-1:0] user;
   } w_beat_t;

   typedef enum logic {IDLE, LOCKED} w_state_t;

endpackage

// File: rtl/axi4_w_arbiter_if.sv
// W-channel arbiter bundle: N_PORTS flattened requesters in, one granted stream out.
interface axi4_w_arbiter_if
   import axi4_w_pkg::*;
#(
   parameter int N_PORTS    = 2,
   parameter int BEAT_CNT_W = 8
);
   logic [N_PORTS-1:0]          io_in_valid;
   logic [N_PORTS-1:0]          io_in_ready;
   logic [N_PORTS*W_DATA_W-1:0] io_in_bits_data;
   logic [N_PORTS-1:0]          io_in_bits_last;
   logic [N_PORTS*W_ID_W-1:0]   io_in_bits_id;
   logic [N_PORTS*W_STRB_W-1:0] io_in_bits_strb;
   logic [N_PORTS*W_USER_W-1:0] io_in_bits_user;

   logic                        io_out_valid;
   logic                        io_out_ready;
   logic [W_DATA_W-1:0]         io_out_bits_data;
   logic                        io_out_bits_last;
   logic [W_ID_W-1:0]           io_out_bits_id;
   logic [W_STRB_W-1:0]         io_out_bits_strb;
   logic [W_USER_W-1:0]         io_out_bits_user;

   logic [N_PORTS-1:0]          io_grant;
   logic                        io_locked;
   logic [BEAT_CNT_W-1:0]       io_beat_count;

   // slave: the arbiter itself; master: requesters plus downstream queue
   modport slave (
      input  io_in_valid, io_in_bits_data, io_in_bits_last, io_in_bits_id,
             io_in_bits_strb, io_in_bits_user, io_out_ready,
      output io_in_ready, io_out_valid, io_out_bits_data, io_out_bits_last,
             io_out_bits_id, io_out_bits_strb, io_out_bits_user,
             io_grant, io_locked, io_beat_count
   );

   modport master (
      output io_in_valid, io_in_bits_data, io_in_bits_last, io_in_bits_id,
             io_in_bits_strb, io_in_bits_user, io_out_ready,
      input  io_in_ready, io_out_valid, io_out_bits_data, io_out_bits_last,
             io_out_bits_id, io_out_bits_strb, io_out_bits_user,
             io_grant, io_locked, io_beat_count
   );

endinterface

// File: rtl/axi4_w_arbiter_rr_pick.sv
// Rotate-priority picker: first set bit of req starting at ptr, wrapping modulo N.
module rr_pick #(
   parameter  int N  = 2,
   localparam int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] idx,
   output logic          any
);

   always_comb begin : pick
      logic [PW:0]   sum;
      logic [PW-1:0] p;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      sum = '0;
      p   = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
         p = sum[PW-1:0];
         if (!any && req[p]) begin
            any    = 1'b1;
            idx    = p;
            gnt[p] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4_w_arbiter.sv
// Burst-locked round-robin arbiter for a shared AXI4 W channel; zero latency, no storage.
module axi4_w_arbiter
   import axi4_w_pkg::*;
#(
   parameter int N_PORTS    = 2,
   parameter int BEAT_CNT_W = 8
) (
   input logic             clk,
   input logic             reset,
   axi4_w_arbiter_if.slave bus
);

   localparam int            PW        = $clog2(N_PORTS);
   localparam logic [PW-1:0] LAST_PORT = PW'(N_PORTS-1);

   w_state_t              state_q, state_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d, lock_port_q, lock_port_d;
   logic [PW-1:0]         sel, pick_idx;
   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [N_PORTS-1:0]    pick_gnt, grant;
   logic                  pick_any, accept;
   w_beat_t               beats [N_PORTS];
   w_beat_t               beat_sel;

   function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
      return (p == LAST_PORT) ? '0 : p + 1'b1;
   endfunction

   for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
      assign beats[k] = '{data: bus.io_in_bits_data[k*W_DATA_W +: W_DATA_W],
                          last: bus.io_in_bits_last[k],
                          id:   bus.io_in_bits_id[k*W_ID_W +: W_ID_W],
                          strb: bus.io_in_bits_strb[k*W_STRB_W +: W_STRB_W],
                          user: bus.io_in_bits_user[k*W_USER_W +: W_USER_W]};
   end

   rr_pick #(.N(N_PORTS)) u_pick (
      .req (bus.io_in_valid),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Reset gates the grant so a valid requester cannot leak through while reset is low.
   always_comb begin
      grant = '0;
      if (state_q == LOCKED) begin
         sel                = lock_port_q;
         grant[lock_port_q] = 1'b1;
      end else begin
         sel   = pick_idx;
         grant = pick_gnt;
      end
      if (!reset) grant = '0;
      beat_sel = beats[sel];
   end

   assign bus.io_out_valid     = |(grant & bus.io_in_valid);
   assign bus.io_in_ready      = grant & {N_PORTS{bus.io_out_ready}};
   assign bus.io_out_bits_data = beat_sel.data;
   assign bus.io_out_bits_last = beat_sel.last;
   assign bus.io_out_bits_id   = beat_sel.id;
   assign bus.io_out_bits_strb = beat_sel.strb;
   assign bus.io_out_bits_user = beat_sel.user;
   assign bus.io_grant         = grant;
   assign bus.io_locked        = (state_q == LOCKED);
   assign bus.io_beat_count    = beat_cnt_q;
   assign accept               = bus.io_out_valid & bus.io_out_ready;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lock_port_d = lock_port_q;
      beat_cnt_d  = beat_cnt_q;
      if (accept) begin
         case (state_q)
            IDLE: begin
               if (beat_sel.last) begin
                  rr_ptr_d = next_port(sel);
               end else begin
                  state_d     = LOCKED;
                  lock_port_d = sel;
                  beat_cnt_d  = BEAT_CNT_W'(1);
               end
            end
            LOCKED: begin
               if (beat_sel.last) begin
                  state_d    = IDLE;
                  rr_ptr_d   = next_port(lock_port_q);
                  beat_cnt_d = '0;
               end else if (beat_cnt_q != '1) begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         lock_port_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_port_q <= lock_port_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_axi4_w_arbiter.sv
// Directed bench for axi4_w_arbiter: 2-port instance for most scenarios, 3-port for pointer wrap.
module tb_axi4_w_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   ncmp  = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   axi4_w_arbiter_if #(.N_PORTS(2), .BEAT_CNT_W(8)) b2 ();
   axi4_w_arbiter_if #(.N_PORTS(3), .BEAT_CNT_W(8)) b3 ();

   axi4_w_arbiter #(.N_PORTS(2), .BEAT_CNT_W(8)) dut2 (.clk(clk), .reset(reset), .bus(b2));
   axi4_w_arbiter #(.N_PORTS(3), .BEAT_CNT_W(8)) dut3 (.clk(clk), .reset(reset), .bus(b3));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int k, input int b);
      return {16'hA5A5, 16'(k), 32'(b)};
   endfunction

   task automatic drv2(input int k, input logic v, input logic l, input logic [63:0] d);
      b2.io_in_valid[k]              = v;
      b2.io_in_bits_last[k]          = l;
      b2.io_in_bits_data[k*64 +: 64] = d;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int b;
      reset = 1'b0;
      b2.io_in_valid     = '0;
      b2.io_in_bits_last = '0;
      b2.io_in_bits_data = '0;
      b2.io_in_bits_id   = {5'd4, 5'd3};
      b2.io_in_bits_strb = {8'h0F, 8'hF0};
      b2.io_in_bits_user = 2'b10;
      b2.io_out_ready    = 1'b0;
      b3.io_in_valid     = '0;
      b3.io_in_bits_last = '0;
      b3.io_in_bits_data = '0;
      b3.io_in_bits_id   = {5'd5, 5'd4, 5'd3};
      b3.io_in_bits_strb = {8'h3C, 8'h0F, 8'hF0};
      b3.io_in_bits_user = 3'b010;
      b3.io_out_ready    = 1'b0;

      // reset held with a requester already valid
      drv2(0, 1'b1, 1'b1, pat(0, 0));
      b2.io_out_ready = 1'b1;
      #2;
      chk("rst_out_valid", b2.io_out_valid, 64'd0);
      chk("rst_in_ready", b2.io_in_ready, 64'd0);
      chk("rst_grant", b2.io_grant, 64'd0);
      chk("rst_locked", b2.io_locked, 64'd0);
      chk("rst_beat_count", b2.io_beat_count, 64'd0);
      step;
      step;
      reset = 1'b1;

      // single-beat round robin
      drv2(0, 1'b1, 1'b1, pat(0, 1));
      drv2(1, 1'b1, 1'b1, pat(1, 1));
      for (int i = 0; i < 4; i++) begin
         settle;
         chk("rr_grant", b2.io_grant, (i % 2 == 0) ? 64'd1 : 64'd2);
         chk("rr_locked", b2.io_locked, 64'd0);
         chk("rr_data", b2.io_out_bits_data, pat(i % 2, 1));
         chk("rr_id", b2.io_out_bits_id, (i % 2 == 0) ? 64'd3 : 64'd4);
         chk("rr_strb", b2.io_out_bits_strb, (i % 2 == 0) ? 64'hF0 : 64'h0F);
         step;
      end

      // burst lock: port 0 takes one beat, then port 1 bursts 4 beats while port 0 waits
      drv2(0, 1'b1, 1'b1, pat(0, 2));
      drv2(1, 1'b1, 1'b0, pat(1, 1));
      settle;
      chk("lock_pre_grant", b2.io_grant, 64'd1);
      step;
      for (int k = 1; k <= 4; k++) begin
         drv2(1, 1'b1, (k == 4), pat(1, k));
         settle;
         chk("lock_grant", b2.io_grant, 64'd2);
         chk("lock_in_ready", b2.io_in_ready, 64'd2);
         chk("lock_data", b2.io_out_bits_data, pat(1, k));
         chk("lock_beat_count", b2.io_beat_count, 64'(k - 1));
         chk("lock_locked", b2.io_locked, (k > 1) ? 64'd1 : 64'd0);
         step;
      end
      settle;
      chk("lock_post_count", b2.io_beat_count, 64'd0);
      chk("lock_post_locked", b2.io_locked, 64'd0);
      chk("lock_post_grant", b2.io_grant, 64'd1);
      b2.io_out_ready = 1'b0;
      step;

      // backpressure: ready toggles during a 3-beat burst on port 0
      b = 1;
      for (int c = 0; c < 5; c++) begin
         b2.io_out_ready = (c % 2 == 0);
         drv2(0, 1'b1, (b == 3), pat(0, 10 + b));
         drv2(1, 1'b1, 1'b1, pat(1, 9));
         settle;
         chk("bp_data", b2.io_out_bits_data, pat(0, 10 + b));
         chk("bp_grant", b2.io_grant, 64'd1);
         chk("bp_out_valid", b2.io_out_valid, 64'd1);
         chk("bp_in_ready", b2.io_in_ready, (c % 2 == 0) ? 64'd1 : 64'd0);
         chk("bp_beat_count", b2.io_beat_count, 64'(b - 1));
         chk("bp_locked", b2.io_locked, (c > 0) ? 64'd1 : 64'd0);
         step;
         if (c % 2 == 0) b++;
      end
      settle;
      chk("bp_post_locked", b2.io_locked, 64'd0);
      chk("bp_post_count", b2.io_beat_count, 64'd0);
      chk("bp_post_grant", b2.io_grant, 64'd2);
      b2.io_out_ready = 1'b0;
      step;

      // 300-beat burst on port 1 saturates the 8-bit counter
      drv2(0, 1'b0, 1'b0, 64'd0);
      b2.io_out_ready = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         drv2(1, 1'b1, (k == 300), pat(1, k));
         settle;
         chk("sat_beat_count", b2.io_beat_count, (k - 1 > 255) ? 64'd255 : 64'(k - 1));
         step;
      end
      drv2(1, 1'b0, 1'b0, 64'd0);
      settle;
      chk("sat_post_count", b2.io_beat_count, 64'd0);
      chk("sat_post_locked", b2.io_locked, 64'd0);
      step;

      // reset after beat 2 of a 5-beat burst on port 1
      for (int k = 1; k <= 2; k++) begin
         drv2(1, 1'b1, 1'b0, pat(1, 20 + k));
         step;
      end
      chk("mid_locked", b2.io_locked, 64'd1);
      chk("mid_beat_count", b2.io_beat_count, 64'd2);
      drv2(1, 1'b1, 1'b0, pat(1, 23));
      drv2(0, 1'b1, 1'b1, pat(0, 30));
      reset = 1'b0;
      #1;
      chk("mid_rst_out_valid", b2.io_out_valid, 64'd0);
      chk("mid_rst_in_ready", b2.io_in_ready, 64'd0);
      chk("mid_rst_locked", b2.io_locked, 64'd0);
      chk("mid_rst_grant", b2.io_grant, 64'd0);
      chk("mid_rst_count", b2.io_beat_count, 64'd0);
      step;
      reset = 1'b1;
      settle;
      chk("post_rst_grant", b2.io_grant, 64'd1);
      chk("post_rst_data", b2.io_out_bits_data, pat(0, 30));
      b2.io_in_valid  = '0;
      b2.io_out_ready = 1'b0;
      step;

      // pointer wrap on the 3-port instance
      b3.io_out_ready               = 1'b1;
      b3.io_in_valid                = 3'b100;
      b3.io_in_bits_last            = 3'b000;
      b3.io_in_bits_data[128 +: 64] = pat(2, 1);
      settle;
      chk("wrap_grant_b1", b3.io_grant, 64'd4);
      chk("wrap_id", b3.io_out_bits_id, 64'd5);
      step;
      b3.io_in_bits_last            = 3'b100;
      b3.io_in_bits_data[128 +: 64] = pat(2, 2);
      settle;
      chk("wrap_grant_b2", b3.io_grant, 64'd4);
      chk("wrap_locked", b3.io_locked, 64'd1);
      step;
      b3.io_in_valid               = 3'b101;
      b3.io_in_bits_last           = 3'b101;
      b3.io_in_bits_data[0 +: 64]  = pat(0, 3);
      settle;
      chk("wrap_grant_next", b3.io_grant, 64'd1);
      chk("wrap_data_next", b3.io_out_bits_data, pat(0, 3));
      chk("wrap_unlocked", b3.io_locked, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
